// File: rtl/link_pkg.sv
// Shared packet geometry, packet types, link FSM states and packet helpers
// for the board-to-board serial link.
package link_pkg;

    localparam int unsigned PKT_LEN   = 208;
    localparam int unsigned BOARD_W   = 162;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    // Field positions inside a packet
    localparam int unsigned SYNC_MSB  = 207;
    localparam int unsigned SYNC_LSB  = 200;
    localparam int unsigned TYPE_MSB  = 199;
    localparam int unsigned TYPE_LSB  = 198;
    localparam int unsigned SEQ_MSB   = 197;
    localparam int unsigned SEQ_LSB   = 190;
    localparam int unsigned BOARD_MSB = 189;
    localparam int unsigned BOARD_LSB = 28;
    localparam int unsigned CSUM_MSB  = 7;
    localparam int unsigned CSUM_LSB  = 0;

    typedef enum logic [1:0] {
        PKT_BOARD = 2'b01,
        PKT_ACK   = 2'b10
    } pkt_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOCAL_TURN,
        ST_SEND_BOARD,
        ST_WAIT_TX,
        ST_WAIT_ACK,
        ST_WAIT_REMOTE,
        ST_SEND_ACK,
        ST_ERROR
    } link_state_t;

    // XOR of every byte above the checksum byte
    function automatic logic [7:0] pkt_checksum(input logic [PKT_LEN-1:0] pkt);
        logic [7:0] c;
        c = '0;
        for (int unsigned i = 1; i < PKT_LEN / 8; i++) begin
            c = c ^ pkt[i*8 +: 8];
        end
        return c;
    endfunction

    function automatic logic [PKT_LEN-1:0] build_pkt(
        input pkt_type_t          ptype,
        input logic [7:0]         seq,
        input logic [BOARD_W-1:0] board
    );
        logic [PKT_LEN-1:0] p;
        p = '0;
        p[SYNC_MSB:SYNC_LSB]   = SYNC_BYTE;
        p[TYPE_MSB:TYPE_LSB]   = ptype;
        p[SEQ_MSB:SEQ_LSB]     = seq;
        p[BOARD_MSB:BOARD_LSB] = board;
        p[CSUM_MSB:CSUM_LSB]   = pkt_checksum(p);
        return p;
    endfunction

endpackage

// File: rtl/link_pkt_parse.sv
// Combinational decode and validation of a received link packet.
module link_pkt_parse
    import link_pkg::*;
(
    input  logic [PKT_LEN-1:0] rx_pkt,
    output logic               is_valid,
    output logic               is_board,
    output logic               is_ack,
    output logic [7:0]         seq,
    output logic [BOARD_W-1:0] board
);

    logic [1:0] pkt_type;
    logic       sync_ok;
    logic       type_ok;
    logic       csum_ok;

    // Field extraction and validity (sync, known type, checksum)
    always_comb begin
        pkt_type = rx_pkt[TYPE_MSB:TYPE_LSB];
        sync_ok  = (rx_pkt[SYNC_MSB:SYNC_LSB] == SYNC_BYTE);
        type_ok  = (pkt_type == PKT_BOARD) || (pkt_type == PKT_ACK);
        csum_ok  = (rx_pkt[CSUM_MSB:CSUM_LSB] == pkt_checksum(rx_pkt));
        is_valid = sync_ok && type_ok && csum_ok;
        is_board = is_valid && (pkt_type == PKT_BOARD);
        is_ack   = is_valid && (pkt_type == PKT_ACK);
        seq      = rx_pkt[SEQ_MSB:SEQ_LSB];
        board    = rx_pkt[BOARD_MSB:BOARD_LSB];
    end

endmodule

// File: rtl/turn_link_ctrl.sv
// Turn sequencing over the serial board link: sends local boards, waits for
// ACKs with timeout/retry, accepts and ACKs remote boards.
module turn_link_ctrl
    import link_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65_000_000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               my_color,
    input  logic               local_move_valid,
    input  logic [BOARD_W-1:0] local_board,
    input  logic               tx_busy,
    output logic               tx_start,
    output logic [PKT_LEN-1:0] tx_pkt,
    input  logic               rx_valid,
    input  logic [PKT_LEN-1:0] rx_pkt,
    output logic               remote_board_valid,
    output logic [BOARD_W-1:0] remote_board,
    output logic               my_turn,
    output logic               link_error
);

    logic               p_valid, p_board, p_ack;
    logic [7:0]         p_seq;
    logic [BOARD_W-1:0] p_brd;

    link_pkt_parse u_parse (
        .rx_pkt   (rx_pkt),
        .is_valid (p_valid),
        .is_board (p_board),
        .is_ack   (p_ack),
        .seq      (p_seq),
        .board    (p_brd)
    );

    link_state_t        state_q, state_d;
    link_state_t        ack_ret_q, ack_ret_d;
    logic [7:0]         tx_seq_q, tx_seq_d;
    logic [7:0]         exp_rx_seq_q, exp_rx_seq_d;
    logic [7:0]         last_rx_seq_q, last_rx_seq_d;
    logic [7:0]         retry_q, retry_d;
    logic [31:0]        timer_q, timer_d;
    logic [BOARD_W-1:0] local_board_q, local_board_d;
    logic               tx_is_ack_q, tx_is_ack_d;
    logic               busy_seen_q, busy_seen_d;
    logic               tx_start_q, tx_start_d;
    logic [PKT_LEN-1:0] tx_pkt_q, tx_pkt_d;
    logic               remote_board_valid_q, remote_board_valid_d;
    logic [BOARD_W-1:0] remote_board_q, remote_board_d;
    logic               my_turn_q, my_turn_d;
    logic               link_error_q, link_error_d;

    logic rx_new;
    logic rx_dup;
    logic rx_ack_ok;
    logic accept;

    // Next-state and next-output computation for the link FSM
    always_comb begin
        state_d              = state_q;
        ack_ret_d            = ack_ret_q;
        tx_seq_d             = tx_seq_q;
        exp_rx_seq_d         = exp_rx_seq_q;
        last_rx_seq_d        = last_rx_seq_q;
        retry_d              = retry_q;
        timer_d              = timer_q;
        local_board_d        = local_board_q;
        tx_is_ack_d          = tx_is_ack_q;
        busy_seen_d          = busy_seen_q;
        tx_start_d           = 1'b0;
        tx_pkt_d             = tx_pkt_q;
        remote_board_valid_d = 1'b0;
        remote_board_d       = remote_board_q;
        accept               = 1'b0;

        rx_new    = rx_valid && p_board && (p_seq == exp_rx_seq_q);
        rx_dup    = rx_valid && p_board && (p_seq == last_rx_seq_q);
        rx_ack_ok = rx_valid && p_ack && (p_seq == tx_seq_q);

        case (state_q)
            ST_IDLE: begin
                state_d = my_color ? ST_WAIT_REMOTE : ST_LOCAL_TURN;
            end
            ST_LOCAL_TURN: begin
                if (local_move_valid) begin
                    local_board_d = local_board;
                    tx_seq_d      = tx_seq_q + 8'd1;
                    retry_d       = '0;
                    state_d       = ST_SEND_BOARD;
                end else if (rx_dup) begin
                    // Our ACK was lost before we moved: re-ACK, keep the turn
                    ack_ret_d = ST_LOCAL_TURN;
                    state_d   = ST_SEND_ACK;
                end
            end
            ST_SEND_BOARD: begin
                if (!tx_busy) begin
                    tx_pkt_d    = build_pkt(PKT_BOARD, tx_seq_q, local_board_q);
                    tx_start_d  = 1'b1;
                    tx_is_ack_d = 1'b0;
                    busy_seen_d = 1'b0;
                    state_d     = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                timer_d = '0;
                if (tx_busy) begin
                    busy_seen_d = 1'b1;
                end else if (busy_seen_q) begin
                    state_d = tx_is_ack_q ? ack_ret_q : ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                timer_d = timer_q + 32'd1;
                if (rx_ack_ok) begin
                    state_d = ST_WAIT_REMOTE;
                end else if (rx_new) begin
                    accept = 1'b1;
                end else if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    if (retry_q < 8'(MAX_RETRY)) begin
                        retry_d = retry_q + 8'd1;
                        state_d = ST_SEND_BOARD;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_WAIT_REMOTE: begin
                if (rx_new) begin
                    accept = 1'b1;
                end else if (rx_dup) begin
                    // Duplicate after we already moved: re-ACK, stay waiting
                    ack_ret_d = ST_WAIT_REMOTE;
                    state_d   = ST_SEND_ACK;
                end
            end
            ST_SEND_ACK: begin
                if (!tx_busy) begin
                    tx_pkt_d    = build_pkt(PKT_ACK, last_rx_seq_q, '0);
                    tx_start_d  = 1'b1;
                    tx_is_ack_d = 1'b1;
                    busy_seen_d = 1'b0;
                    state_d     = ST_WAIT_TX;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // New remote board (explicit in WAIT_REMOTE or implicit ACK in WAIT_ACK)
        if (accept) begin
            remote_board_d       = p_brd;
            remote_board_valid_d = 1'b1;
            last_rx_seq_d        = p_seq;
            exp_rx_seq_d         = exp_rx_seq_q + 8'd1;
            ack_ret_d            = ST_LOCAL_TURN;
            state_d              = ST_SEND_ACK;
        end

        my_turn_d    = (state_d == ST_LOCAL_TURN);
        link_error_d = (state_d == ST_ERROR);
    end

    // State and registered outputs, synchronous active-high reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q              <= ST_IDLE;
            ack_ret_q            <= ST_LOCAL_TURN;
            tx_seq_q             <= '0;
            exp_rx_seq_q         <= 8'd1;
            last_rx_seq_q        <= '0;
            retry_q              <= '0;
            timer_q              <= '0;
            local_board_q        <= '0;
            tx_is_ack_q          <= 1'b0;
            busy_seen_q          <= 1'b0;
            tx_start_q           <= 1'b0;
            tx_pkt_q             <= '0;
            remote_board_valid_q <= 1'b0;
            remote_board_q       <= '0;
            my_turn_q            <= 1'b0;
            link_error_q         <= 1'b0;
        end else begin
            state_q              <= state_d;
            ack_ret_q            <= ack_ret_d;
            tx_seq_q             <= tx_seq_d;
            exp_rx_seq_q         <= exp_rx_seq_d;
            last_rx_seq_q        <= last_rx_seq_d;
            retry_q              <= retry_d;
            timer_q              <= timer_d;
            local_board_q        <= local_board_d;
            tx_is_ack_q          <= tx_is_ack_d;
            busy_seen_q          <= busy_seen_d;
            tx_start_q           <= tx_start_d;
            tx_pkt_q             <= tx_pkt_d;
            remote_board_valid_q <= remote_board_valid_d;
            remote_board_q       <= remote_board_d;
            my_turn_q            <= my_turn_d;
            link_error_q         <= link_error_d;
        end
    end

    assign tx_start           = tx_start_q;
    assign tx_pkt             = tx_pkt_q;
    assign remote_board_valid = remote_board_valid_q;
    assign remote_board       = remote_board_q;
    assign my_turn            = my_turn_q;
    assign link_error         = link_error_q;

endmodule
